// File: rtl/edge_detect_pkg.sv
// Shared mode encodings and edge-qualification helper for the multi-channel edge detector.
package edge_detect_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  // new_level is the value level takes on; bit 0 of the mode enables rises, bit 1 falls.
  function automatic logic edge_hit(input mode_t mode, input logic new_level);
    return (new_level & mode[0]) | (~new_level & mode[1]);
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchroniser, optional debounce (EDGE_DETECT_MC_DEBOUNCE_EN), edge qualification, pending flag.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 4,
  parameter logic RST_LEVEL   = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in,
  input  mode_t mode,
  input  logic  clr,
  output logic  level,
  output logic  pulse,
  output logic  pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   upd;
  logic                   hit;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

`ifdef EDGE_DETECT_MC_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Any cycle where s agrees with level restarts the stability count.
  assign upd = (s != level) && (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((s == level) || upd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // Without the counter level follows s every cycle; DEB_CYCLES has no effect.
  assign upd = (s != level) && (DEB_CYCLES > 0);
`endif

  assign hit = upd & edge_hit(mode, s);

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= RST_LEVEL;
      pulse   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (upd) begin
        level <= s;
      end
      pulse   <= hit;
      pending <= hit | (pending & ~clr);
    end
  end

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector top: per-channel instances plus the irq OR.
// Debounce is built only when EDGE_DETECT_MC_DEBOUNCE_EN is defined.
module edge_detect_mc
  import edge_detect_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_CYCLES  = 4,
  parameter logic RST_LEVEL   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   pulse,
  output logic [CH-1:0]   pending,
  output logic            irq
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .RST_LEVEL  (RST_LEVEL)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .mode   (mode_t'(mode[2*i +: 2])),
      .clr    (clr[i]),
      .level  (level[i]),
      .pulse  (pulse[i]),
      .pending(pending[i])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_edge_detect_mc.sv
// Self-checking bench for edge_detect_mc: directed scenarios plus random traffic against a
// trace-window reference model (a level flips once the delayed input has disagreed with it for DEB cycles).
module tb_edge_detect_mc;

  localparam int   CH    = 4;
  localparam int   SYNC  = 2;
  localparam int   DEB   = 4;
  localparam logic RSTL  = 1'b1;
  localparam int   MAXC  = 4096;
`ifdef EDGE_DETECT_MC_DEBOUNCE_EN
  localparam int   DEB_EFF = DEB;
`else
  localparam int   DEB_EFF = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   in_s;
  logic [2*CH-1:0] mode_s;
  logic [CH-1:0]   clr_s;
  logic [CH-1:0]   level_s, pulse_s, pending_s;
  logic            irq_s;

  int errors = 0;
  int checks = 0;

  logic          trace [CH][MAXC];
  int            cyc = 0;
  int            rst_edge = 0;
  logic [CH-1:0] lm, pm, qm;

  edge_detect_mc #(.CH(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .RST_LEVEL(RSTL)) dut (
    .clk(clk), .rst(rst), .in(in_s), .mode(mode_s), .clr(clr_s),
    .level(level_s), .pulse(pulse_s), .pending(pending_s), .irq(irq_s)
  );

  always #5 clk = ~clk;

  // Synchronised input seen by the filter for samples taken at edge e.
  function automatic logic s_at(input int ch, input int e);
    return (e >= rst_edge + 1) ? trace[ch][e] : RSTL;
  endfunction

  // Advance one clock edge, update the reference model from the inputs sampled there.
  task automatic tick();
    int  k;
    logic stable;
    @(posedge clk);
    k = cyc;
    if (k >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", k, MAXC);
      $fatal(1);
    end
    for (int ch = 0; ch < CH; ch++) trace[ch][k] = in_s[ch];
    if (rst) begin
      lm = {CH{RSTL}};
      pm = '0;
      qm = '0;
      rst_edge = k;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        stable = (k - DEB_EFF + 1 > rst_edge);
        for (int j = 0; j < DEB_EFF; j++)
          if (s_at(ch, k - j - SYNC) == lm[ch]) stable = 1'b0;
        pm[ch] = 1'b0;
        if (stable) begin
          lm[ch] = ~lm[ch];
          pm[ch] = lm[ch] ? mode_s[2*ch] : mode_s[2*ch+1];
        end
        qm[ch] = pm[ch] | (qm[ch] & ~clr_s[ch]);
      end
    end
    cyc = k + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_s = 4'hF; mode_s = 8'h00; clr_s = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if ({level_s, pulse_s, pending_s, irq_s} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got lvl=%h pul=%h pend=%h irq=%b exp lvl=f pul=0 pend=0 irq=0",
                 cyc, level_s, pulse_s, pending_s, irq_s);
      end
    end
  endtask

  task automatic test_rise_only();
    int seen = 0;
    int at = -1;
    mode_s = 8'b00_00_00_01;
    in_s[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
        errors++;
        $display("FAIL rise_fall_phase cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
      end
    end
    in_s[0] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (pulse_s[0]) begin seen++; at = n; end
      checks++;
      if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
        errors++;
        $display("FAIL rise_phase cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
      end
    end
    checks++;
    if (seen != 1 || at != SYNC + DEB_EFF || pending_s[0] !== 1'b1 || irq_s !== 1'b1) begin
      errors++;
      $display("FAIL rise_latency got pulses=%0d at_edge=%0d pend0=%b irq=%b exp pulses=1 at_edge=%0d pend0=1 irq=1",
               seen, at, pending_s[0], irq_s, SYNC + DEB_EFF);
    end
  endtask

  task automatic test_glitch();
    mode_s = 8'b00_00_11_01;
    for (int len = 3; len <= 4; len++) begin
      in_s[1] = 1'b0;
      repeat (len) begin
        tick();
        checks++;
        if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
          errors++;
          $display("FAIL glitch_%0d cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                   len, cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
        end
      end
      in_s[1] = 1'b1;
      repeat (12) begin
        tick();
        checks++;
        if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
          errors++;
          $display("FAIL glitch_%0d_tail cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                   len, cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
        end
      end
    end
  endtask

  task automatic test_clr_collision();
    mode_s = 8'b00_11_00_00;
    clr_s = 4'hF;
    tick();
    clr_s = 4'h0;
    in_s[2] = ~in_s[2];
    repeat (SYNC + DEB_EFF + 3) tick();
    in_s[2] = ~in_s[2];
    repeat (SYNC + DEB_EFF - 1) tick();
    clr_s = 4'b0100;
    tick();
    checks++;
    if (pending_s[2] !== 1'b1 || pulse_s[2] !== 1'b1 || pending_s !== qm) begin
      errors++;
      $display("FAIL clr_set_collision got pend=%h pul2=%b exp pend2=1 pul2=1 model_pend=%h",
               pending_s, pulse_s[2], qm);
    end
    tick();
    checks++;
    if (pending_s !== 4'h0 || irq_s !== 1'b0 || qm !== 4'h0) begin
      errors++;
      $display("FAIL clr_next got pend=%h irq=%b exp pend=0 irq=0", pending_s, irq_s);
    end
    clr_s = 4'h0;
  endtask

  task automatic test_toggle_mode();
    int p3 = 0;
    int bad0 = 0;
    mode_s = 8'b11_00_00_00;
    for (int t = 0; t < 8; t++) begin
      in_s[3] = ~in_s[3];
      in_s[0] = ~in_s[0];
      repeat (12) begin
        tick();
        if (pulse_s[3]) p3++;
        if (pulse_s[0] || pending_s[0]) bad0++;
        checks++;
        if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
          errors++;
          $display("FAIL toggle cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                   cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
        end
      end
    end
    checks++;
    if (p3 != 8 || bad0 != 0) begin
      errors++;
      $display("FAIL toggle_counts got pulse3=%0d ch0_events=%0d exp pulse3=8 ch0_events=0", p3, bad0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    in_s = 4'hF; mode_s = 8'hFF;
    repeat (SYNC + DEB_EFF + 4) tick();
    in_s[1] = 1'b0;
    repeat (SYNC + 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({level_s, pulse_s, pending_s, irq_s} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got %h/%h/%h/%b exp f/0/0/0", level_s, pulse_s, pending_s, irq_s);
    end
    while (level_s[1] !== 1'b0 && n < 20) begin
      tick();
      n++;
      checks++;
      if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
        errors++;
        $display("FAIL reset_restart cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
      end
    end
    checks++;
    if (n != SYNC + DEB_EFF) begin
      errors++;
      $display("FAIL reset_restart_latency got edges=%0d exp %0d", n, SYNC + DEB_EFF);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < CH; ch++)
        if ($urandom_range(0, 4) == 0) in_s[ch] = ~in_s[ch];
      if ($urandom_range(0, 40) == 0) mode_s = 8'($urandom);
      clr_s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 250) == 0);
      tick();
      checks++;
      if ({level_s, pulse_s, pending_s, irq_s} !== {lm, pm, qm, |qm}) begin
        errors++;
        $display("FAIL random cyc=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 cyc, level_s, pulse_s, pending_s, irq_s, lm, pm, qm, |qm);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_only();
    test_glitch();
    test_clr_collision();
    test_toggle_mode();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
